// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction bus request/response handshake
interface fetch_unit_if;
    logic        instruction_request;
    logic [31:0] instruction_address;
    logic        instruction_response;
    logic [31:0] instruction_data;
    modport master (
        output instruction_request,
        output instruction_address,
        input  instruction_response,
        input  instruction_data
    );
    modport slave (
        input  instruction_request,
        input  instruction_address,
        output instruction_response,
        output instruction_data
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a DEPTH-entry prefetch queue and redirect/discard handling
module fetch_unit #(
    parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] NOP          = 32'h00000033,
    localparam int         CW           = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus,
    input  logic          redirect,
    input  logic [31:0]   redirect_address,
    input  logic          stall,
    output logic          ifid_valid,
    output logic [31:0]   ifid_instruction,
    output logic [31:0]   ifid_pc,
    output logic [CW-1:0] queue_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {RUN, DISCARD} state_t;
    state_t        state;
    logic          live;
    logic [31:0]   fetch_pc;
    logic [31:0]   pending_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc_q  [DEPTH];
    logic [31:0]   ins_q [DEPTH];
    logic          push;
    logic          pop;
    logic [31:0]   target;
    // live holds request low until the first edge with reset released
    assign bus.instruction_request = live && (state == DISCARD || count < CW'(DEPTH));
    assign bus.instruction_address = fetch_pc;
    assign ifid_valid       = count != '0;
    assign ifid_instruction = ifid_valid ? ins_q[rd_ptr] : NOP;
    assign ifid_pc          = ifid_valid ? pc_q[rd_ptr] : BOOT_ADDRESS;
    assign queue_count      = count;
    assign target           = redirect_address & ~32'd3;
    assign pop              = ifid_valid && !stall && !redirect;
    assign push             = state == RUN && bus.instruction_request && bus.instruction_response && !redirect;
    // Queue storage; entries are only visible while counted, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]  <= fetch_pc;
            ins_q[wr_ptr] <= bus.instruction_data;
        end
    end
    // Fetch state machine: redirect flushes and either retargets now or waits out the pending response
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            live       <= 1'b0;
            fetch_pc   <= BOOT_ADDRESS;
            pending_pc <= BOOT_ADDRESS;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            live <= 1'b1;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                if (!bus.instruction_request || bus.instruction_response) begin
                    state    <= RUN;
                    fetch_pc <= target;
                end else begin
                    state      <= DISCARD;
                    pending_pc <= target;
                end
            end else if (state == DISCARD) begin
                if (bus.instruction_response) begin
                    state    <= RUN;
                    fetch_pc <= pending_pc;
                end
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue-level reference model for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] BOOT  = 32'h00000000;
    localparam logic [31:0] NOPV  = 32'h00000033;
    localparam logic [31:0] KEY   = 32'h5A5A0000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] redirect_address = 32'h0;
    logic        ifid_valid;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc;
    logic [2:0]  queue_count;

    int n_chk = 0;
    int n_pass = 0;
    int lat = 0;
    bit force_resp = 1'b0;
    int wcnt = 0;
    int wnext = 0;

    fetch_unit_if bus();

    fetch_unit #(.BOOT_ADDRESS(BOOT), .DEPTH(DEPTH), .NOP(NOPV)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .redirect(redirect),
        .redirect_address(redirect_address),
        .stall(stall),
        .ifid_valid(ifid_valid),
        .ifid_instruction(ifid_instruction),
        .ifid_pc(ifid_pc),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Memory responder: answers a held request after lat wait cycles, data derived from the address
    always @(negedge clk)
        wnext = (bus.instruction_request === 1'b1 && bus.instruction_response === 1'b0) ? wcnt + 1 : 0;
    always @(posedge clk) begin
        #2;
        wcnt = wnext;
        bus.instruction_response = force_resp || (bus.instruction_request === 1'b1 && wcnt >= lat);
        bus.instruction_data = bus.instruction_address ^ KEY;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc = BOOT;
    logic [31:0] mpend = BOOT;
    bit          mdisc = 1'b0;
    bit          mlive = 1'b0;

    // Reference model: compare this cycle's outputs, then apply the inputs seen at the coming edge
    always @(negedge clk) begin : model
        bit mreq;
        mreq = mlive && (mdisc || mq.size() < DEPTH);
        chk("request", 32'(bus.instruction_request), 32'(mreq));
        chk("address", bus.instruction_address, mpc);
        chk("ifid_valid", 32'(ifid_valid), 32'(mq.size() > 0));
        chk("ifid_pc", ifid_pc, mq.size() > 0 ? mq[0].pc : BOOT);
        chk("ifid_instruction", ifid_instruction, mq.size() > 0 ? mq[0].ins : NOPV);
        chk("queue_count", 32'(queue_count), 32'(mq.size()));
        if (reset) begin
            mq.delete();
            mpc = BOOT;
            mdisc = 1'b0;
            mlive = 1'b0;
        end else begin
            if (redirect) begin
                mq.delete();
                if (mreq && !bus.instruction_response) begin
                    mdisc = 1'b1;
                    mpend = redirect_address & ~32'd3;
                end else begin
                    mdisc = 1'b0;
                    mpc = redirect_address & ~32'd3;
                end
            end else if (mdisc) begin
                if (bus.instruction_response) begin
                    mdisc = 1'b0;
                    mpc = mpend;
                end
            end else begin
                if (mq.size() > 0 && !stall) void'(mq.pop_front());
                if (mreq && bus.instruction_response) begin
                    mq.push_back('{mpc, mpc ^ KEY});
                    mpc = mpc + 32'd4;
                end
            end
            mlive = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait streaming after reset
        do_reset();
        mid();
        chk("rst request", 32'(bus.instruction_request), 32'd0);
        chk("rst address", bus.instruction_address, BOOT);
        chk("rst ifid_valid", 32'(ifid_valid), 32'd0);
        chk("rst ifid_instruction", ifid_instruction, NOPV);
        chk("rst ifid_pc", ifid_pc, BOOT);
        chk("rst queue_count", 32'(queue_count), 32'd0);
        tick(); mid();
        chk("first request", 32'(bus.instruction_request), 32'd1);
        chk("first address", bus.instruction_address, 32'h0);
        tick(); mid();
        chk("stream pc0", ifid_pc, 32'h0);
        chk("stream ins0", ifid_instruction, KEY);
        chk("stream addr4", bus.instruction_address, 32'h4);
        tick(); mid();
        chk("stream pc4", ifid_pc, 32'h4);
        chk("stream addr8", bus.instruction_address, 32'h8);
        repeat (6) tick();

        // Full queue under stall; a response with request low is ignored
        stall = 1'b1;
        do_reset();
        repeat (5) tick();
        force_resp = 1'b1;
        mid();
        chk("full count", 32'(queue_count), 32'd4);
        chk("full request", 32'(bus.instruction_request), 32'd0);
        chk("full address", bus.instruction_address, 32'h10);
        tick();
        force_resp = 1'b0;
        stall = 1'b0;
        mid();
        chk("full stale ignored", 32'(queue_count), 32'd4);
        chk("full head", ifid_pc, 32'h0);
        tick();
        stall = 1'b1;
        mid();
        chk("pop request", 32'(bus.instruction_request), 32'd1);
        chk("pop address", bus.instruction_address, 32'h10);
        chk("pop count", 32'(queue_count), 32'd3);
        chk("pop head", ifid_pc, 32'h4);

        // 3-wait bus, redirect while the request for 0x8 is outstanding
        stall = 1'b0;
        lat = 3;
        do_reset();
        for (int i = 0; i < 40 && !(bus.instruction_request && bus.instruction_address == 32'h8); i++) tick();
        chk("wait addr8", bus.instruction_address, 32'h8);
        tick();
        redirect = 1'b1;
        redirect_address = 32'h200;
        tick();
        redirect = 1'b0;
        mid();
        chk("discard addr held", bus.instruction_address, 32'h8);
        chk("discard valid", 32'(ifid_valid), 32'd0);
        chk("discard request", 32'(bus.instruction_request), 32'd1);
        for (int i = 0; i < 20 && bus.instruction_address == 32'h8; i++) tick();
        chk("discard next addr", bus.instruction_address, 32'h200);

        // Redirect to unaligned target with a same-cycle response
        lat = 0;
        repeat (6) tick();
        redirect = 1'b1;
        redirect_address = 32'h103;
        tick();
        redirect = 1'b0;
        mid();
        chk("redir count", 32'(queue_count), 32'd0);
        chk("redir valid", 32'(ifid_valid), 32'd0);
        chk("redir addr", bus.instruction_address, 32'h100);
        tick(); mid();
        chk("redir head", ifid_pc, 32'h100);
        chk("redir next", bus.instruction_address, 32'h104);

        // PC wrap at the top of the address space
        tick();
        redirect = 1'b1;
        redirect_address = 32'hFFFFFFFC;
        tick();
        redirect = 1'b0;
        mid();
        chk("wrap addr", bus.instruction_address, 32'hFFFFFFFC);
        tick(); mid();
        chk("wrap head", ifid_pc, 32'hFFFFFFFC);
        chk("wrap ins", ifid_instruction, 32'hFFFFFFFC ^ KEY);
        chk("wrap next", bus.instruction_address, 32'h0);

        // Reset during DISCARD, stale response arrives with request low
        lat = 100;
        tick();
        tick();
        redirect = 1'b1;
        redirect_address = 32'h300;
        tick();
        redirect = 1'b0;
        mid();
        chk("pre-reset discard", 32'(bus.instruction_request), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lat = 0;
        force_resp = 1'b1;
        mid();
        chk("post-reset request", 32'(bus.instruction_request), 32'd0);
        tick();
        force_resp = 1'b0;
        mid();
        chk("post-reset count", 32'(queue_count), 32'd0);
        chk("post-reset addr", bus.instruction_address, BOOT);
        tick(); mid();
        chk("post-reset head", ifid_pc, BOOT);
        chk("post-reset valid", 32'(ifid_valid), 32'd1);

        // Mixed stall, latency and redirect traffic
        for (int i = 0; i < 60; i++) begin
            tick();
            stall = (i % 3 == 0) || (i % 5 == 1);
            lat = (i / 15) % 3;
            redirect = (i == 25) || (i == 44);
            redirect_address = (i == 25) ? 32'h406 : 32'h80;
        end
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the Grande Risco 5 pipeline. It replaces the single-register IF/ID handoff with a DEPTH-entry prefetch queue, so decode stalls do not block the instruction bus. It holds the fetch PC and issues word fetches over a request/response instruction bus. On a redirect from branch/jump resolution it flushes the queue and discards any in-flight response. The decode stage consumes its head entry directly.

## Interface
- BOOT_ADDRESS, 32'h00000000, fetch PC after reset (word aligned)
- DEPTH, 4, prefetch queue entries; power of two, >= 2
- NOP, 32'h00000033, value driven on ifid_instruction when queue empty
- CW, $clog2(DEPTH+1), width of queue_count (derived, do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- instruction_request  out  1  fetch request valid
- instruction_address  out  32  word address of current request
- instruction_response  in  1  current request completes this cycle; data valid
- instruction_data  in  32  fetched word, valid with instruction_response
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_address  in  32  new PC; bits [1:0] ignored (forced 0)
- stall  in  1  decode not accepting this cycle
- ifid_valid  out  1  queue head valid
- ifid_instruction  out  32  queue head instruction, NOP when empty
- ifid_pc  out  32  queue head PC, BOOT_ADDRESS when empty
- queue_count  out  CW  occupied entries, 0..DEPTH

## Operation
- Reset: synchronous, active-high, clock clk. All state clears in the same edge.
- Queue: circular FIFO of {pc, instruction}. Read/write pointers wrap modulo DEPTH. Show-ahead: head is visible combinationally on ifid_*.
- Consume: ifid_valid && !stall && !redirect pops the head.
- Enqueue: instruction_request && instruction_response in RUN with !redirect pushes {fetch_pc, instruction_data}, then fetch_pc += 4. The addition is 32-bit wrapping: 0xFFFFFFFC -> 0x00000000.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Bus rule: once instruction_request is high, instruction_address stays stable until instruction_response. The bus has no abort.
- State RUN:
  - instruction_request = (count < DEPTH); instruction_address = fetch_pc.
  - redirect with no pending request, or with a response this cycle: flush queue, fetch_pc <= redirect_address & ~3, stay RUN. Any same-cycle response data is dropped.
  - redirect while request is high and no response: flush queue, pending_pc <= redirect_address & ~3, go to DISCARD.
- State DISCARD:
  - instruction_request = 1; instruction_address = old fetch_pc (held).
  - Response: data dropped, fetch_pc <= pending_pc, go to RUN.
  - Another redirect without a response: pending_pc updated, queue stays empty.
  - Redirect together with a response: fetch_pc <= new redirect address, go to RUN.
  - No enqueue and no consume (queue is empty).
- Redirect takes priority over pop and push in every state.

## Timing
- Reset values:
  - instruction_request 0, instruction_address BOOT_ADDRESS
  - ifid_valid 0, ifid_instruction NOP, ifid_pc BOOT_ADDRESS
  - queue_count 0, state RUN
- Because reset is synchronous, request rises in the first cycle after reset deasserts.
- Zero-wait bus (response in the request cycle): the word is on ifid_* one cycle later. Sustained throughput is 1 instruction/cycle with stall low.
- N-wait bus: a word reaches ifid N+1 cycles after request rises. Next request is presented the cycle after the response.
- Full queue (count == DEPTH): request deasserts. A pop in cycle k re-enables request in cycle k+1.
- Redirect in cycle k:
  - ifid_valid = 0 in cycle k+1.
  - instruction_address = redirect target in k+1 (RUN), or in the cycle after the discarded response (DISCARD).
- Reset asserted mid-DISCARD: drops the state unconditionally. The stale response then arrives with request low and is ignored; only responses to a high request are accepted.
- queue_count, ifid_* and instruction_* are combinational from registered state only. There is no input-to-output combinational path except through the documented stall/redirect pop and priority logic (affecting state only).

## Test plan
- Reset then zero-wait bus, stall low: addresses 0x0, 0x4, 0x8… on consecutive cycles. ifid_pc 0x0 appears in cycle 2 after reset release, then increments by 4 every cycle.
- DEPTH=4, stall held high, zero-wait bus: queue_count reaches 4, request drops, address frozen at 0x10. Release stall one cycle: pop pc 0x0, request 0x10 next cycle.
- 3-wait bus, redirect to 0x200 one cycle after request for 0x8: address held at 0x8 until response, that word never appears on ifid, next request is 0x200.
- Redirect to 0x103 with simultaneous response in RUN: response dropped, queue_count 0 next cycle, next address 0x100.
- fetch_pc at 0xFFFFFFFC, zero-wait bus: enqueued ifid_pc 0xFFFFFFFC, next address 0x00000000.
- Reset asserted while in DISCARD with response pending, response arrives one cycle after reset deasserts: response ignored, first accepted word comes from BOOT_ADDRESS.
